// File: rtl/adrv9001_tx_sample_buffer_if.sv
// Word channel from the DMA/DSP source into the TX sample buffer.
// tdata carries packed IQ: I[31:16], Q[15:0]; tlast marks the end of a burst.
interface adrv9001_tx_sample_buffer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adrv9001_tx_sample_buffer.sv
// Elastic buffer between the TX word source and the serdes unpack stage: prefill, then one word per din_rdy.
// Optional burst mode (tlast carried per word, RUN->FILL after a tlast pop): define ADRV9001_TX_BURST_TLAST_EN.
module adrv9001_tx_sample_buffer #(
  parameter int DEPTH             = 16,
  parameter int START_LEVEL       = 8,
  parameter int HOLD_ON_UNDERFLOW = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       enable,
  adrv9001_tx_sample_buffer_if.slave s_axis,
  input  logic                       din_rdy,
  output logic [31:0]                dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       running,
  output logic                       underflow,
  output logic                       overflow,
  output logic [15:0]                underflow_cnt,
  input  logic                       clr_status
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef ADRV9001_TX_BURST_TLAST_EN
  localparam int MW = 33;
`else
  localparam int MW = 32;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [31:0]   dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          underflow_q, underflow_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   uf_cnt_q, uf_cnt_d;

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] wr_word;
  logic [MW-1:0] rd_word;

  logic pop_req, pop_ok, pop_empty;
  logic tready, wr_en;
  logic start_ok, burst_end;

  // A pop frees a slot on the same edge, so a full FIFO still accepts a word while popping.
  always_comb begin
    pop_req   = (state_q == ST_RUN) && din_rdy && enable;
    pop_ok    = pop_req && (level_q != '0);
    pop_empty = pop_req && (level_q == '0);
    tready    = (state_q != ST_IDLE) && ((level_q < LW'(DEPTH)) || pop_ok);
    wr_en     = s_axis.tvalid && tready && enable;
  end

  assign rd_word = mem[rd_ptr_q];

`ifdef ADRV9001_TX_BURST_TLAST_EN
  logic [LW-1:0] tlast_cnt_q, tlast_cnt_d;

  assign wr_word   = {s_axis.tlast, s_axis.tdata};
  assign burst_end = pop_ok && rd_word[32];

  // Words with tlast still in the FIFO; any of them lets a short burst start without reaching START_LEVEL.
  always_comb begin
    tlast_cnt_d = tlast_cnt_q + LW'(wr_en && s_axis.tlast) - LW'(burst_end);
    if (!enable) begin
      tlast_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tlast_cnt_q <= '0;
    end else begin
      tlast_cnt_q <= tlast_cnt_d;
    end
  end

  assign start_ok = (level_d >= LW'(START_LEVEL)) || (tlast_cnt_d != '0);
`else
  logic unused_tlast;

  assign unused_tlast = s_axis.tlast;
  assign wr_word      = s_axis.tdata;
  assign burst_end    = 1'b0;
  assign start_ok     = (level_d >= LW'(START_LEVEL));
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    level_d  = level_q + LW'(wr_en) - LW'(pop_ok);
    if (!enable) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_FILL;
      ST_FILL: if (start_ok)  state_d = ST_RUN;
      ST_RUN:  if (burst_end) state_d = ST_FILL;
      default: state_d = ST_IDLE;
    endcase
    if (!enable) begin
      state_d = ST_IDLE;
    end
  end

  // dout holds between pops; an empty pop either repeats the last word or zeroes it.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if ((state_q != ST_RUN) || !enable) begin
      dout_d       = '0;
      dout_valid_d = 1'b0;
    end else if (pop_ok) begin
      dout_d       = rd_word[31:0];
      dout_valid_d = 1'b1;
    end else if (pop_empty) begin
      dout_d       = (HOLD_ON_UNDERFLOW != 0) ? dout_q : '0;
      dout_valid_d = 1'b0;
    end
  end

  always_comb begin
    underflow_d = underflow_q | pop_empty;
    overflow_d  = overflow_q | ((state_q == ST_RUN) && s_axis.tvalid && !tready);
    uf_cnt_d    = uf_cnt_q;
    if (pop_empty && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_d = uf_cnt_q + 16'd1;
    end
    if (clr_status) begin
      underflow_d = 1'b0;
      overflow_d  = 1'b0;
      uf_cnt_d    = '0;
    end
  end

  // NOTE: the storage array has no reset; level and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      underflow_q  <= 1'b0;
      overflow_q   <= 1'b0;
      uf_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      underflow_q  <= underflow_d;
      overflow_q   <= overflow_d;
      uf_cnt_q     <= uf_cnt_d;
    end
  end

  assign s_axis.tready = tready;
  assign dout          = dout_q;
  assign dout_valid    = dout_valid_q;
  assign level         = level_q;
  assign running       = (state_q == ST_RUN);
  assign underflow     = underflow_q;
  assign overflow      = overflow_q;
  assign underflow_cnt = uf_cnt_q;

endmodule

// File: doc/adrv9001_tx_sample_buffer.md
Name: adrv9001_tx_sample_buffer

Overview:
- TX-path elastic buffer directly upstream of the TX serdes unpack stage.
- Accepts 32-bit packed IQ words from an AXI-stream source (DMA/DSP), stores them in a small synchronous FIFO, and presents one word per unpack request on din/din_valid.
- Provides prefill-before-start, underflow fill policy and sticky/saturating error reporting so TX gaps are deterministic and observable.

Parameters:
- DEPTH, 16, FIFO depth in 32-bit words; power of two, 4..256.
- START_LEVEL, 8, words required in FIFO before leaving FILL; 1..DEPTH.
- HOLD_ON_UNDERFLOW, 0, 1 = repeat last word on underflow, 0 = output 32'h0.

Ports:
- clk  in  1  sample clock, shared with the unpack stage
- rstn  in  1  asynchronous active-low reset
- enable  in  1  run request; low flushes FIFO and returns to IDLE
- s_tdata  in  32  packed IQ word: I[31:16], Q[15:0]
- s_tvalid  in  1  AXI-stream valid
- s_tready  out  1  AXI-stream ready
- s_tlast  in  1  end of burst (used only with optional feature)
- din_rdy  in  1  request from unpack stage
- dout  out  32  word to unpack din
- dout_valid  out  1  to unpack din_valid
- level  out  clog2(DEPTH)+1  current FIFO occupancy
- running  out  1  high in RUN state
- underflow  out  1  sticky; set on pop from empty FIFO in RUN
- overflow  out  1  sticky; set when s_tvalid is high and s_tready is low while in RUN
- underflow_cnt  out  16  saturating count of underflow events
- clr_status  in  1  synchronous clear of sticky flags and count

Behaviour:
- Reset (rstn low, asynchronous) drives:
  - dout=0, dout_valid=0, level=0, running=0, underflow=0, overflow=0, underflow_cnt=0, s_tready=0.
  - FSM to IDLE; FIFO pointers to 0.
- Write side:
  - s_tready = (state != IDLE) and (level < DEPTH).
  - A word is written when s_tvalid and s_tready are both high.
- FSM states:
  - IDLE: FIFO held empty. Go to FILL when enable=1.
  - FILL: accept writes; dout_valid=0; dout=0. Go to RUN when level >= START_LEVEL.
  - RUN: serve pops. Go to IDLE when enable=0.
  - enable=0 in any state: IDLE on the next edge, FIFO flushed, dout_valid=0.
- Pop timing in RUN:
  - Pop occurs on each rising edge where din_rdy=1.
  - dout/dout_valid are registered on that same edge, so new data appears one cycle after din_rdy is high.
  - dout holds between pops.
- Empty FIFO at a pop in RUN:
  - dout_valid=0.
  - dout = last word if HOLD_ON_UNDERFLOW=1, else 0.
  - underflow set; underflow_cnt increments and saturates at 16'hFFFF.
  - FSM stays in RUN.
- Simultaneous write and pop: level unchanged; a write into a full FIFO in the same cycle as a pop is accepted (s_tready may be computed with the pop included).
- Pointers wrap modulo DEPTH; level saturates logically at DEPTH via s_tready.
- clr_status has priority over a simultaneous set, and clears to 0 that cycle.
- running = (state == RUN).

Optional Feature:
- Macro: ADRV9001_TX_BURST_TLAST_EN.
- Defined:
  - Each stored word carries its tlast bit.
  - When a word with tlast=1 is popped, FSM goes RUN→FILL after that pop; subsequent pops until refill give dout_valid=0 without setting underflow.
  - A burst shorter than START_LEVEL starts on tlast receipt.
- Undefined: s_tlast ignored; FIFO stores 32 bits only.

Test Plan:
- Prefill:
  - Stimulus: rstn low then high, enable=1, write 8 words 0x00010001..0x00080008, din_rdy toggling every cycle.
  - Required: running rises after the 8th write; first dout=0x00010001 with dout_valid=1 one cycle after the first din_rdy in RUN.
- Steady stream: source supplies 1 word per 2 cycles matching unpack rate for 1000 words → output order identical to input, underflow=0, level stays within 7..9.
- Underflow:
  - Stimulus: stop s_tvalid after 8 words, HOLD_ON_UNDERFLOW=1.
  - Required: 9th pop gives dout_valid=0 with dout held at the last word; underflow=1, underflow_cnt=1; 3 further empty pops give underflow_cnt=4; clr_status → 0.
- Full/backpressure: din_rdy=0, write 20 words with DEPTH=16 → s_tready low at level=16, 16 words accepted; overflow=1 only in RUN.
- Async reset mid-RUN: drop rstn during a pop → all outputs 0 immediately without a clock edge; after release, IDLE with level=0.
- TLAST (macro defined): 3-word burst with tlast on word 3, START_LEVEL=8 → RUN entered, 3 valid words out, then FILL with dout_valid=0 and underflow=0.
